csr_file_irq: RTL and testbench

//  Machine-mode CSR file, next generation of the RV32IM core's CSR block. Adds 64-bit counters with high halves,

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_counter64.sv | 29 ++
 rtl/csr_file_irq.sv | 196 +++++++++++++++++++
 tb/tb_csr_file_irq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Machine-mode CSR file shared definitions.
// Addresses, status/interrupt bit positions, op encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPM3     = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHPM3H    = 12'hB83;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MS_MIE  = 3;
  localparam int MS_MPIE = 7;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  localparam logic [31:0] MISA_VAL = 32'h4000_1100;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with independently writable halves.
// A half write wins over the increment in the same cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  logic [63:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_wr_lo) begin
      r_cnt[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_cnt[63:32] <= i_wdata;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/csr_file_irq.sv
// Machine-mode CSR file: counters, trap sequencing and
// prioritised (optionally vectored) interrupt delivery.
module csr_file_irq
  import csr_pkg::*;
#(
  parameter int          NUM_HPM     = 2,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0,
  parameter bit          VECTOR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wr_suppress,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic [(NUM_HPM>0?NUM_HPM:1)-1:0] hpm_event,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  input  logic        sw_irq,
  input  logic        trap_enter,
  input  logic [30:0] exc_cause,
  input  logic        trap_exit,
  input  logic [31:0] current_pc,
  output logic        irq_take,
  output logic [31:0] trap_target,
  output logic [31:0] mepc_out
);

  localparam int HN = (NUM_HPM > 0) ? NUM_HPM : 1;

  csr_op_e     w_op;
  logic        r_ms_mie, r_ms_mpie;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0] w_cyc, w_ret;
  logic [63:0] w_hpm [HN];
  logic [31:0] w_mstatus, w_mip, w_rdata, w_wval, w_cause;
  logic        w_hit, w_wr_req, w_we, w_trap;
  logic [2:0]  w_pend;
  logic [3:0]  w_code;

  assign w_op = csr_op_e'(csr_op);

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_ms_mpie,
                      3'd0, r_ms_mie, 3'd0};
  assign w_mip = {20'd0, ext_irq, 3'd0, tmr_irq,
                  3'd0, sw_irq, 3'd0};

  always_comb begin
    w_rdata = '0;
    w_hit   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MISA:      w_rdata = MISA_VAL;
      CSR_MIE:       w_rdata = r_mie;
      CSR_MTVEC:     w_rdata = r_mtvec;
      CSR_MSCRATCH:  w_rdata = r_mscratch;
      CSR_MEPC:      w_rdata = r_mepc;
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MIP:       w_rdata = w_mip;
      CSR_MCYCLE,
      CSR_CYCLE:     w_rdata = w_cyc[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:    w_rdata = w_cyc[63:32];
      CSR_MINSTRET,
      CSR_INSTRET:   w_rdata = w_ret[31:0];
      CSR_MINSTRETH,
      CSR_INSTRETH:  w_rdata = w_ret[63:32];
      CSR_MHARTID:   w_rdata = HART_ID;
      default:       w_hit   = 1'b0;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (csr_addr == CSR_MHPM3 + 12'(i)) begin
        w_rdata = w_hpm[i][31:0];
        w_hit   = 1'b1;
      end
      if (csr_addr == CSR_MHPM3H + 12'(i)) begin
        w_rdata = w_hpm[i][63:32];
        w_hit   = 1'b1;
      end
    end
  end

  assign csr_rdata = w_rdata;

  // 0xC00-0xFFF is read-only space; a real write there traps
  assign w_wr_req    = (w_op != OP_NONE) && !csr_wr_suppress;
  assign csr_illegal = !w_hit ||
                       ((csr_addr[11:10] == 2'b11) && w_wr_req);
  assign w_we        = w_wr_req && !csr_illegal;

  always_comb begin
    unique case (w_op)
      OP_RS:   w_wval = w_rdata | csr_wdata;
      OP_RC:   w_wval = w_rdata & ~csr_wdata;
      default: w_wval = csr_wdata;
    endcase
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (1'b1),
    .i_wr_lo (w_we && (csr_addr == CSR_MCYCLE)),
    .i_wr_hi (w_we && (csr_addr == CSR_MCYCLEH)),
    .i_wdata (w_wval),
    .o_count (w_cyc)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (instr_retire),
    .i_wr_lo (w_we && (csr_addr == CSR_MINSTRET)),
    .i_wr_hi (w_we && (csr_addr == CSR_MINSTRETH)),
    .i_wdata (w_wval),
    .o_count (w_ret)
  );

  for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
    csr_counter64 u_hpm (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (hpm_event[g]),
      .i_wr_lo (w_we && (csr_addr == CSR_MHPM3 + 12'(g))),
      .i_wr_hi (w_we && (csr_addr == CSR_MHPM3H + 12'(g))),
      .i_wdata (w_wval),
      .o_count (w_hpm[g])
    );
  end
  if (NUM_HPM == 0) begin : g_nohpm
    assign w_hpm[0] = '0;
  end

  assign w_pend = {ext_irq & r_mie[11],
                   tmr_irq & r_mie[7],
                   sw_irq  & r_mie[3]};

  always_comb begin
    w_code = CODE_MTI;
    if (w_pend[2])      w_code = CODE_MEI;
    else if (w_pend[0]) w_code = CODE_MSI;
  end

  assign irq_take = r_ms_mie && (|w_pend) &&
                    !trap_enter && !trap_exit;
  assign w_trap   = trap_enter || irq_take;
  assign w_cause  = trap_enter ? {1'b0, exc_cause}
                               : {1'b1, 27'd0, w_code};

  assign trap_target = (r_mtvec & ~32'h3) +
    ((r_mtvec[0] && irq_take) ? {26'd0, w_code, 2'b00} : 32'd0);
  assign mepc_out = r_mepc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ms_mie   <= 1'b0;
      r_ms_mpie  <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      if (w_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_ms_mie  <= w_wval[MS_MIE];
            r_ms_mpie <= w_wval[MS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_wval & MIE_MASK;
          CSR_MTVEC:    r_mtvec    <= {w_wval[31:2], 1'b0,
                                       VECTOR_EN & w_wval[0]};
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= w_wval & ~32'h3;
          CSR_MCAUSE:   r_mcause   <= w_wval;
          default: ;
        endcase
      end
      // trap sequencing overrides any same-cycle CSR write
      if (w_trap) begin
        r_mepc    <= current_pc & ~32'h3;
        r_mcause  <= w_cause;
        r_ms_mpie <= r_ms_mie;
        r_ms_mie  <= 1'b0;
      end else if (trap_exit) begin
        r_ms_mie  <= r_ms_mpie;
        r_ms_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file_irq.sv
// Randomised and directed bench for csr_file_irq against a
// CSR-level behavioural model.
module tb_csr_file_irq;

  localparam int          NH     = 2;
  localparam logic [31:0] HID    = 32'd3;
  localparam logic [31:0] TV_RST = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  op;
  logic [11:0] addr;
  logic [31:0] wd;
  logic        sup;
  logic [31:0] rdata;
  logic        ill;
  logic        ret;
  logic [NH-1:0] ev;
  logic        ext, tmr, sw, te, tx;
  logic [30:0] cause;
  logic [31:0] pc;
  logic        take;
  logic [31:0] tgt, mepc;

  int n_chk = 0;
  int n_err = 0;

  bit          m_mie, m_mpie;
  logic [31:0] m_mier, m_mtvec, m_mscr, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;
  logic [63:0] m_hpm [NH];

  logic [11:0] addrs [25] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
    12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'hC00, 12'hC80,
    12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'hB05, 12'hC03,
    12'h345};

  always #5 clk = ~clk;

  csr_file_irq #(
    .NUM_HPM(NH), .HART_ID(HID),
    .MTVEC_RESET(TV_RST), .VECTOR_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_op(op), .csr_addr(addr), .csr_wdata(wd),
    .csr_wr_suppress(sup),
    .csr_rdata(rdata), .csr_illegal(ill),
    .instr_retire(ret), .hpm_event(ev),
    .ext_irq(ext), .tmr_irq(tmr), .sw_irq(sw),
    .trap_enter(te), .exc_cause(cause), .trap_exit(tx),
    .current_pc(pc),
    .irq_take(take), .trap_target(tgt), .mepc_out(mepc)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mier = 0; m_mtvec = TV_RST; m_mscr = 0;
    m_mepc = 0; m_mcause = 0;
    m_cyc = 0; m_ret = 0;
    for (int i = 0; i < NH; i++) m_hpm[i] = 0;
  endtask

  function automatic logic [31:0] mread(input logic [11:0] a,
                                        output bit ok);
    logic [31:0] v;
    v = '0;
    ok = 1'b1;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 32'h0)
                            | (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_1100;
      12'h304: v = m_mier;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscr;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = (ext ? 32'h800 : 32'h0) | (tmr ? 32'h80 : 32'h0)
                 | (sw ? 32'h8 : 32'h0);
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      12'hF14: v = HID;
      default: begin
        ok = 1'b0;
        for (int i = 0; i < NH; i++) begin
          if (a == 12'hB03 + 12'(i)) begin
            v = m_hpm[i][31:0]; ok = 1'b1;
          end
          if (a == 12'hB83 + 12'(i)) begin
            v = m_hpm[i][63:32]; ok = 1'b1;
          end
        end
      end
    endcase
    return v;
  endfunction

  function automatic void irq_model(output bit tk,
                                    output logic [31:0] tg,
                                    output logic [3:0] cd);
    bit pe, ps, pt;
    pe = ext && m_mier[11];
    ps = sw && m_mier[3];
    pt = tmr && m_mier[7];
    cd = pe ? 4'd11 : (ps ? 4'd3 : 4'd7);
    tk = m_mie && (pe || ps || pt) && !te && !tx;
    tg = (m_mtvec & ~32'h3) +
         ((m_mtvec[0] && tk) ? 32'(cd) * 32'd4 : 32'h0);
  endfunction

  task automatic idle();
    op = 2'd0; addr = 12'h300; wd = 0; sup = 0;
    ret = 0; ev = 0; ext = 0; tmr = 0; sw = 0;
    te = 0; tx = 0; cause = 0; pc = 0;
  endtask

  task automatic settle();
    bit ok, tk, wr;
    logic [31:0] exp_rd, tg;
    logic [3:0] cd;
    #2;
    exp_rd = mread(addr, ok);
    wr = (op != 2'd0) && !sup;
    irq_model(tk, tg, cd);
    check("illegal", 32'(ill),
          32'(!ok || ((addr[11:10] == 2'b11) && wr)));
    if (ok) check("rdata", rdata, exp_rd);
    check("irq_take", 32'(take), 32'(tk));
    check("trap_target", tgt, tg);
    check("mepc_out", mepc, m_mepc);
  endtask

  task automatic tick();
    bit ok, tk, we, omie, ompie;
    logic [31:0] old, wv, tg;
    logic [3:0] cd;
    if (reset_n) begin
      old = mread(addr, ok);
      irq_model(tk, tg, cd);
      we = (op != 2'd0) && !sup && ok && (addr[11:10] != 2'b11);
      case (op)
        2'd2:    wv = old | wd;
        2'd3:    wv = old & ~wd;
        default: wv = wd;
      endcase
      omie = m_mie;
      ompie = m_mpie;
      m_cyc = (we && addr == 12'hB00) ? {m_cyc[63:32], wv} :
              (we && addr == 12'hB80) ? {wv, m_cyc[31:0]} :
              m_cyc + 64'd1;
      m_ret = (we && addr == 12'hB02) ? {m_ret[63:32], wv} :
              (we && addr == 12'hB82) ? {wv, m_ret[31:0]} :
              m_ret + 64'(ret);
      for (int i = 0; i < NH; i++) begin
        if (we && addr == 12'hB03 + 12'(i))
          m_hpm[i] = {m_hpm[i][63:32], wv};
        else if (we && addr == 12'hB83 + 12'(i))
          m_hpm[i] = {wv, m_hpm[i][31:0]};
        else
          m_hpm[i] = m_hpm[i] + 64'(ev[i]);
      end
      if (we) begin
        case (addr)
          12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
          12'h304: m_mier = wv & 32'h888;
          12'h305: m_mtvec = {wv[31:2], 1'b0, wv[0]};
          12'h340: m_mscr = wv;
          12'h341: m_mepc = wv & ~32'h3;
          12'h342: m_mcause = wv;
          default: ;
        endcase
      end
      if (te || tk) begin
        m_mepc = pc & ~32'h3;
        m_mcause = te ? {1'b0, cause} : {28'h8000000, cd};
        m_mpie = omie;
        m_mie = 1'b0;
      end else if (tx) begin
        m_mie = ompie;
        m_mpie = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, input string tag,
                    input logic [31:0] exp);
    idle();
    addr = a;
    settle();
    check(tag, rdata, exp);
    tick();
  endtask

  task automatic wr(input logic [1:0] o, input logic [11:0] a,
                    input logic [31:0] d);
    idle();
    op = o; addr = a; wd = d;
    settle();
    tick();
  endtask

  task automatic reset_mid();
    idle();
    addr = 12'hB00;
    #1 reset_n = 1'b0;
    model_reset();
    #1 check("rst_mcycle", rdata, 32'h0);
    check("rst_irq_take", 32'(take), 32'h0);
    check("rst_mepc", mepc, 32'h0);
    addr = 12'h305;
    #1 check("rst_mtvec", rdata, TV_RST);
    addr = 12'h300;
    #1 check("rst_mstatus", rdata, 32'h1800);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      idle();
      op = 2'($urandom_range(0, 3));
      addr = addrs[$urandom_range(0, 24)];
      wd = $urandom;
      sup = ($urandom_range(0, 7) == 0);
      ret = 1'($urandom);
      ev = NH'($urandom);
      ext = ($urandom_range(0, 3) == 0);
      tmr = ($urandom_range(0, 3) == 0);
      sw = ($urandom_range(0, 3) == 0);
      te = ($urandom_range(0, 15) == 0);
      tx = ($urandom_range(0, 15) == 0);
      cause = 31'($urandom);
      pc = $urandom;
      settle();
      tick();
    end

    reset_mid();

    wr(2'd2, 12'h300, 32'h8);
    rd(12'h300, "rs_mstatus", 32'h1808);
    idle();
    op = 2'd2; addr = 12'h300; wd = 32'h8; sup = 1'b1;
    settle();
    check("suppress_rdata", rdata, 32'h1808);
    tick();
    rd(12'h300, "suppress_keep", 32'h1808);
    wr(2'd3, 12'h300, 32'h8);
    rd(12'h300, "rc_mstatus", 32'h1800);
    rd(12'hF14, "mhartid", HID);
    rd(12'h301, "misa", 32'h4000_1100);
    idle();
    addr = 12'h7C0;
    settle();
    check("unimpl_illegal", 32'(ill), 32'h1);
    tick();

    wr(2'd1, 12'hB00, 32'hFFFF_FFFE);
    wr(2'd1, 12'hB80, 32'h0);
    repeat (3) begin idle(); settle(); tick(); end
    rd(12'hB00, "mcycle_wrap", 32'h1);
    rd(12'hB80, "mcycleh_carry", 32'h1);
    idle();
    op = 2'd1; addr = 12'hC00; wd = 32'h5;
    settle();
    check("ro_write_illegal", 32'(ill), 32'h1);
    tick();
    rd(12'hB00, "ro_write_nochg", 32'h4);

    wr(2'd2, 12'h300, 32'h8);
    wr(2'd1, 12'h304, 32'h888);
    idle();
    ext = 1; tmr = 1; pc = 32'h100;
    settle();
    check("irq_take_ext", 32'(take), 32'h1);
    check("irq_target_direct", tgt, TV_RST);
    tick();
    rd(12'h342, "irq_mcause", 32'h8000_000B);
    rd(12'h341, "irq_mepc", 32'h100);
    rd(12'h300, "irq_mstatus", 32'h1880);

    wr(2'd1, 12'h305, 32'h1001);
    wr(2'd2, 12'h300, 32'h8);
    idle();
    tmr = 1; pc = 32'h300;
    settle();
    check("vec_irq_take", 32'(take), 32'h1);
    check("vec_target", tgt, 32'h101C);
    te = 1; cause = 31'd2;
    settle();
    check("exc_no_irq", 32'(take), 32'h0);
    check("exc_target", tgt, 32'h1000);
    tick();
    rd(12'h342, "exc_mcause", 32'h2);

    wr(2'd2, 12'h300, 32'h8);
    idle();
    te = 1; cause = 31'd5; pc = 32'h200;
    op = 2'd1; addr = 12'h341; wd = 32'h44;
    settle();
    tick();
    rd(12'h341, "trap_beats_wr", 32'h200);
    idle();
    tx = 1;
    settle();
    tick();
    rd(12'h300, "mret_mstatus", 32'h1888);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
